div_i12_o12_seq: RTL and testbench

//   Iterative radix-2 restoring divider; the inverse operation of the 6x6->12 multiplier benchmarks.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_if.sv | 27 ++
 rtl/div_step.sv | 17 +
 rtl/div_i12_o12_seq.sv | 119 +++++++++++
 tb/tb_div_i12_o12_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider (div_i12_o12_seq).
package div_pkg;
  localparam int DEF_A_W = 6;
  localparam int CNT_W   = $clog2(DEF_A_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_if.sv
// Operand/result handshake bundle for div_i12_o12_seq; the master drives operands, the slave returns results.
interface div_if
  import div_pkg::*;
#(
  parameter int A_W = DEF_A_W
) ();
  logic               in_valid;
  logic               in_ready;
  logic [2*A_W-1:0]   dividend;
  logic [A_W-1:0]     divisor;
  logic               out_valid;
  logic               out_ready;
  logic [A_W-1:0]     quotient;
  logic [A_W-1:0]     remainder;
  logic               div_zero;
  logic               ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int A_W = 6
) (
  input  logic [A_W-1:0] r,
  input  logic           din,
  input  logic [A_W-1:0] divisor,
  output logic [A_W-1:0] r_nxt,
  output logic           q_bit
);
  logic [A_W:0] r_sh;

  // r < divisor on entry, so whichever value is kept fits back into A_W bits
  assign r_sh  = {r, din};
  assign q_bit = (r_sh >= {1'b0, divisor});
  assign r_nxt = q_bit ? A_W'(r_sh - {1'b0, divisor}) : r_sh[A_W-1:0];
endmodule

// File: rtl/div_i12_o12_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional macro DIV_FASTPATH_EN: divisor==1 and dividend<divisor finish in one cycle.
module div_i12_o12_seq
  import div_pkg::*;
#(
  parameter int A_W = DEF_A_W
) (
  input  logic   clk,
  input  logic   rst,
  div_if.slave   bus,
  output state_t state_dbg
);
  localparam int P_W = 2 * A_W;
  localparam int CW  = (A_W > 1) ? $clog2(A_W) : 1;

  state_t         state, state_nxt;
  logic           accept;
  logic           quick;
  logic [A_W-1:0] hi, lo;
  logic [A_W-1:0] r_q, lo_q, q_q, dvs_q;
  logic [CW-1:0]  cnt_q;
  logic           dz_q, ovf_q;
  logic [A_W-1:0] r_step;
  logic           q_bit;

  assign hi     = bus.dividend[P_W-1:A_W];
  assign lo     = bus.dividend[A_W-1:0];
  assign accept = bus.in_valid & bus.in_ready;

  div_step #(.A_W(A_W)) u_step (
    .r       (r_q),
    .din     (lo_q[A_W-1]),
    .divisor (dvs_q),
    .r_nxt   (r_step),
    .q_bit   (q_bit)
  );

  always_comb begin
    quick = (bus.divisor == '0) || (hi >= bus.divisor);
`ifdef DIV_FASTPATH_EN
    if ((bus.divisor == A_W'(1)) || (bus.dividend < {{A_W{1'b0}}, bus.divisor}))
      quick = 1'b1;
`endif
  end

  // valid/ready: a transfer happens on a rising edge where both are high.
  // in_ready is high only in IDLE; out_valid only in DONE, result held until out_ready.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = quick ? DONE : CALC;
      end
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      lo_q  <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      dvs_q <= bus.divisor;
      lo_q  <= lo;
      cnt_q <= CW'(A_W - 1);
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
      q_q   <= '0;
      r_q   <= hi;
      if (bus.divisor == '0) begin
        dz_q <= 1'b1;
        q_q  <= '1;
        r_q  <= lo;
      end else if (hi >= bus.divisor) begin
        ovf_q <= 1'b1;
        q_q   <= '1;
        r_q   <= '0;
      end
`ifdef DIV_FASTPATH_EN
      else if (bus.divisor == A_W'(1)) begin
        q_q <= lo;
        r_q <= '0;
      end else if (bus.dividend < {{A_W{1'b0}}, bus.divisor}) begin
        q_q <= '0;
        r_q <= lo;
      end
`endif
    end else if (state == CALC) begin
      r_q   <= r_step;
      q_q   <= {q_q[A_W-2:0], q_bit};
      lo_q  <= {lo_q[A_W-2:0], 1'b0};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_div_i12_o12_seq.sv
// Bench for div_i12_o12_seq: directed cases, backpressure, mid-operation reset and random operands.
module tb_div_i12_o12_seq;
  import div_pkg::*;

  localparam int A_W = 6;

  logic   clk;
  logic   rst;
  state_t state_dbg;

  int checks = 0;
  int errors = 0;

  // {p[31:20], d[19:14], q[13:8], r[7:2], div_zero, ovf}
  logic [31:0] exp_q[$];

  div_if #(.A_W(A_W)) bus ();

  div_i12_o12_seq #(.A_W(A_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [11:0] p, input logic [5:0] d);
    int pi, di, q, r;
    logic dz, ov;
    pi = int'(p);
    di = int'(d);
    dz = 1'b0;
    ov = 1'b0;
    if (di == 0) begin
      dz = 1'b1; q = 63; r = pi % 64;
    end else if (pi / di > 63) begin
      ov = 1'b1; q = 63; r = 0;
    end else begin
      q = pi / di; r = pi % di;
    end
    return {p, d, q[5:0], r[5:0], dz, ov};
  endfunction

  function automatic int exp_lat(input logic [11:0] p, input logic [5:0] d);
    if (d == 0 || int'(p) / int'(d) > 63) return 1;
`ifdef DIV_FASTPATH_EN
    if (d == 1 || int'(p) < int'(d)) return 1;
`endif
    return A_W + 1;
  endfunction

  bit rand_bp = 1'b0;

  task automatic send(input logic [11:0] p, input logic [5:0] d, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(n), 32'(0));
    bus.dividend = p;
    bus.divisor  = d;
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(model(p, d));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_lat(input logic [11:0] p, input logic [5:0] d);
    int lat = 1;
    send(p, d, 1'b1);
    while (lat < 50) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat(p, d)));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("quotient",  32'(bus.quotient),  32'(e[13:8]));
        check("remainder", 32'(bus.remainder), 32'(e[7:2]));
        check("div_zero",  32'(bus.div_zero),  32'(e[1]));
        check("ovf",       32'(bus.ovf),       32'(e[0]));
        if (!e[1] && !e[0]) begin
          check("recon", 32'(bus.quotient) * 32'(e[19:14]) + 32'(bus.remainder), 32'(e[31:20]));
          check("rem_lt_div", 32'(bus.remainder < e[19:14]), 32'(1));
        end
      end
    end
  end

  initial begin
    logic [11:0] p;
    logic [5:0]  d, q, r;
    int n;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_state",     32'(state_dbg),     32'(IDLE));
    check("rst_in_ready",  32'(bus.in_ready),  32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_quotient",  32'(bus.quotient),  32'(0));
    check("rst_remainder", 32'(bus.remainder), 32'(0));
    check("rst_flags",     32'({bus.div_zero, bus.ovf}), 32'(0));

    run_lat(12'd2047, 6'd45);
    run_lat(12'd2025, 6'd45);
    run_lat(12'd0,    6'd63);
    run_lat(12'd100,  6'd0);
    run_lat(12'd4032, 6'd3);
    run_lat(12'd2016, 6'd32);
    run_lat(12'd2048, 6'd32);
    run_lat(12'd63,   6'd1);
    run_lat(12'd5,    6'd9);
    run_lat(12'd4095, 6'd63);

    // Backpressure with ignored in_valid pulses during CALC and DONE.
    bus.out_ready = 1'b0;
    send(12'd2047, 6'd45, 1'b1);
    bus.dividend = 12'd100;
    bus.divisor  = 6'd0;
    bus.in_valid = 1'b1;
    repeat (2) begin
      check("busy_in_ready_calc", 32'(bus.in_ready), 32'(0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", 32'(bus.out_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      check("hold_in_ready",  32'(bus.in_ready),  32'(0));
      check("hold_quotient",  32'(bus.quotient),  32'(45));
      check("hold_remainder", 32'(bus.remainder), 32'(22));
      check("hold_valid",     32'(bus.out_valid), 32'(1));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_accept_in_ready",  32'(bus.in_ready),  32'(1));
    check("post_accept_out_valid", 32'(bus.out_valid), 32'(0));

    // Reset on the third CALC cycle abandons the operation.
    send(12'd2047, 6'd45, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_rst_calc", 32'(state_dbg), 32'(CALC));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  32'(bus.in_ready),  32'(1));
    check("abort_quotient",  32'(bus.quotient),  32'(0));
    check("abort_remainder", 32'(bus.remainder), 32'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(bus.out_valid), 32'(0));
    end
    @(posedge clk); #1;

    rand_bp = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = 12'($urandom_range(0, 4095));
        d = 6'($urandom_range(0, 63));
      end else begin
        d = 6'($urandom_range(1, 63));
        q = 6'($urandom_range(0, 63));
        r = 6'($urandom_range(0, int'(d) - 1));
        p = 12'(int'(q) * int'(d) + int'(r));
      end
      send(p, d, 1'b1);
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
